// File: rtl/ps2_key_event_if.sv
// Scan-code input strobe and key-event handshake between the PS/2 byte receiver,
// the key-event stage (slave) and the event consumer / stimulus side (master).
interface ps2_key_event_if;
  logic [7:0] code_in;
  logic       code_valid;
  logic       code_err;
  logic [7:0] evt_key;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output code_in, code_valid, code_err, evt_ready,
    input  evt_key, evt_ext, evt_break, evt_valid
  );

  modport slave (
    input  code_in, code_valid, code_err, evt_ready,
    output evt_key, evt_ext, evt_break, evt_valid
  );
endinterface

// File: rtl/ps2_key_event.sv
// PS/2 scan-code sequence parser (E0/F0/E1 prefixes) feeding a show-ahead event FIFO.
// Optional repeat-make suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2_key_event_if.slave  bus,
  output logic            overflow,
  output logic [7:0]      err_cnt,
  input  logic            stat_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  typedef struct packed {
    state_t     state;
    logic [2:0] skip;
    logic       push;
    logic       ext;
    logic       brk;
  } dec_t;

  typedef struct packed {
    logic [7:0] key;
    logic       ext;
    logic       brk;
  } evt_t;

  function automatic logic is_prefix(input logic [7:0] c);
    return (c == 8'hE0) || (c == 8'hF0) || (c == 8'hE1);
  endfunction

  // Interpretation of a byte arriving with no sequence in progress; also used
  // to restart cleanly when a prefix shows up out of order.
  function automatic dec_t idle_decode(input logic [7:0] c, input logic [2:0] skip);
    dec_t d;
    d = '{state: IDLE, skip: skip, push: 1'b0, ext: 1'b0, brk: 1'b0};
    case (c)
      8'hE0: d.state = EXT;
      8'hF0: d.state = BRK;
      8'hE1: begin
        d.state = PAUSE;
        d.skip  = 3'd7;
      end
      8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF: d.state = IDLE;
      default: d.push = 1'b1;
    endcase
    return d;
  endfunction

  state_t          state;
  logic [2:0]      skip_cnt;
  logic [TW-1:0]   tmo_cnt;
  dec_t            dec;
  logic [7:0]      key_c;
  logic            err_inc;
  logic            push;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    dec     = '{state: state, skip: skip_cnt, push: 1'b0, ext: 1'b0, brk: 1'b0};
    key_c   = bus.code_in;
    err_inc = 1'b0;
    if (bus.code_valid) begin
      if (bus.code_err) begin
        dec.state = IDLE;
        err_inc   = 1'b1;
      end else begin
        case (state)
          IDLE: dec = idle_decode(bus.code_in, skip_cnt);
          EXT: begin
            if (bus.code_in == 8'hF0) dec.state = EXT_BRK;
            else begin
              dec = idle_decode(bus.code_in, skip_cnt);
              if (dec.push) dec.ext = 1'b1;
            end
          end
          BRK, EXT_BRK: begin
            if (is_prefix(bus.code_in)) dec = idle_decode(bus.code_in, skip_cnt);
            else begin
              dec.state = IDLE;
              dec.push  = 1'b1;
              dec.ext   = (state == EXT_BRK);
              dec.brk   = 1'b1;
            end
          end
          PAUSE: begin
            if (skip_cnt == 3'd1) begin
              dec.state = IDLE;
              dec.skip  = 3'd0;
              dec.push  = 1'b1;
              dec.ext   = 1'b1;
              key_c     = 8'hE1;
            end else begin
              dec.skip = skip_cnt - 3'd1;
            end
          end
          default: dec.state = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
      tmo_cnt  <= '0;
    end else if (bus.code_valid) begin
      state    <= dec.state;
      skip_cnt <= dec.skip;
      tmo_cnt  <= '0;
    end else if (state != IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       tm_valid;
  logic [7:0] tm_key;
  logic       tm_ext;
  logic       tm_hit;

  assign tm_hit = tm_valid && (tm_key == key_c) && (tm_ext == dec.ext);
  assign push   = dec.push && !(tm_hit && !dec.brk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_valid <= 1'b0;
      tm_key   <= 8'h00;
      tm_ext   <= 1'b0;
    end else begin
      if (stat_clr) tm_valid <= 1'b0;
      if (dec.push && !dec.brk && !tm_hit) begin
        tm_valid <= 1'b1;
        tm_key   <= key_c;
        tm_ext   <= dec.ext;
      end else if (dec.push && dec.brk && tm_hit) begin
        tm_valid <= 1'b0;
      end
    end
  end
`else
  assign push = dec.push;
`endif

  evt_t          mem [FIFO_DEPTH];
  evt_t          wdata;
  evt_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_nxt;
  logic          full, pop, write, drop;

  assign wdata   = '{key: key_c, ext: dec.ext, brk: dec.brk};
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = bus.evt_valid && bus.evt_ready;
  assign write   = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_next = rd_ptr + 1'b1;

  always_comb begin
    count_nxt = count;
    if (write && !pop)      count_nxt = count + 1'b1;
    else if (pop && !write) count_nxt = count - 1'b1;
  end

  // NOTE: storage carries no reset; count and evt_valid alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= wdata;
  end

  // Output registers are preloaded with whatever will be the head after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      head          <= '0;
      bus.evt_valid <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_next;
      count         <= count_nxt;
      bus.evt_valid <= (count_nxt != '0);
      if (write && ((count == '0) || (pop && count == (AW+1)'(1)))) head <= wdata;
      else if (pop && count > (AW+1)'(1))                           head <= mem[rd_next];
    end
  end

  assign bus.evt_key   = head.key;
  assign bus.evt_ext   = head.ext;
  assign bus.evt_break = head.brk;

  // A new overflow or error in the same cycle as stat_clr takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (drop)          overflow <= 1'b1;
      else if (stat_clr) overflow <= 1'b0;
      if (err_inc)       err_cnt  <= stat_clr ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
      else if (stat_clr) err_cnt  <= 8'd0;
    end
  end

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Downstream stage of the PS/2 keyboard receiver.
- Consumes received scan-code bytes, resolves the E0 (extended), F0 (break) and E1 (pause) prefix sequences, and emits one make/break key event per complete sequence.
- Events are buffered in a small FIFO with a valid/ready handshake to the consumer (character mapper / game logic).
- Also reports receive errors and overflow status.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1000000, clk cycles a partial prefix sequence may idle before it is discarded.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- code_in  input  8  received scan-code byte.
- code_valid  input  1  single-cycle strobe qualifying code_in and code_err.
- code_err  input  1  parity/framing error on the strobed byte.
- evt_key  output  8  final scan-code byte of the event (0xE1 for pause).
- evt_ext  output  1  1 if the sequence carried an E0 or E1 prefix.
- evt_break  output  1  1 = key release, 0 = key press.
- evt_valid  output  1  head FIFO entry is valid.
- evt_ready  input  1  consumer accepts the head entry.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- err_cnt  output  8  saturating count of code_err strobes.
- stat_clr  input  1  synchronous clear of overflow and err_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; evt_valid=0; evt_key=0x00; evt_ext=0; evt_break=0.
  - overflow=0; err_cnt=0; state=IDLE; timeout counter=0.
  - Typematic register cleared.
  - Asserting reset mid-sequence or mid-handshake discards everything.
- Parser states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Bytes are processed only when code_valid=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with skip counter=7.
  - FA, AA, FE, EE, 00, FF are ignored and stay in IDLE.
  - Any other byte pushes {key, ext=0, brk=0}.
- EXT:
  - F0 -> EXT_BRK.
  - Ignored bytes (as listed for IDLE) -> IDLE.
  - Other bytes push {key, 1, 0} -> IDLE.
- BRK: any non-prefix byte pushes {key, 0, 1} -> IDLE.
- EXT_BRK: any non-prefix byte pushes {key, 1, 1} -> IDLE.
- Unexpected prefix in EXT, BRK or EXT_BRK (E0/F0/E1 out of order): abandon the partial sequence and reinterpret the byte as if received in IDLE.
- PAUSE:
  - Each byte decrements the skip counter.
  - When it reaches 0, push {0xE1, 1, 0} -> IDLE. No break event is ever generated for pause.
- code_err=1 with code_valid:
  - Byte discarded, state -> IDLE, err_cnt increments (saturates at 255).
- Timeout:
  - Counter resets on every code_valid and counts while state != IDLE.
  - On reaching TIMEOUT_CYCLES: state -> IDLE, nothing pushed.
- Latency:
  - The final byte is strobed in cycle N; the entry is written at the end of N.
  - With an empty FIFO, evt_valid=1 and the outputs are valid in cycle N+1.
- FIFO:
  - Show-ahead; outputs are registered from the head entry.
  - Pop occurs when evt_valid && evt_ready.
  - evt_key, evt_ext and evt_break hold stable while evt_valid=1 and evt_ready=0.
  - Push when full without a simultaneous pop: event dropped, overflow<=1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop in the same cycle when empty: the entry appears the next cycle; no bypass.
- stat_clr: clears overflow and err_cnt next edge. If it coincides with a new overflow or error, the set/increment wins (overflow=1, err_cnt=1).

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds {key, ext} of the last emitted make event.
  - A make matching it is suppressed (not pushed).
  - A break matching it pushes normally and clears the register.
  - A different make overwrites it.
  - Reset and stat_clr clear the register.
- Undefined: every make is pushed and the register is not synthesized.

Test Plan:
- Basic make/break: bytes 2B; F0 2B with evt_ready=1 -> events {2B,0,0} then {2B,0,1}; evt_valid high exactly one cycle after each final strobe.
- Extended break: E0 F0 75 -> single event {75,1,1}. Then E0 FA 1C -> only {1C,0,0} (E0 abandoned by ignored byte FA).
- Overflow: FIFO_DEPTH=4, evt_ready=0, send 1C 1D 1E 1F 20 -> four events held, 5th dropped, overflow=1. Raise evt_ready -> 1C,1D,1E,1F drained in order. stat_clr -> overflow=0.
- Timeout and error: E0, idle TIMEOUT_CYCLES+1, then 1C -> {1C,0,0}. Strobe 2B with code_err=1 -> no event, err_cnt=1. Then F0 2B -> {2B,0,1}.
- Pause: E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}, no break.
- Typematic: 1C 1C 1C F0 1C -> macro defined: {1C,0,0},{1C,0,1}. Macro undefined: three makes then one break.
